// File: rtl/jtframe_pocket_pkg.sv
// Shared constants and types for the Pocket scaler video capture block.
// Defaults match the Pocket scaler's 12-bit, two-beat pixel bus.
package jtframe_pocket_pkg;

  localparam int unsigned PocketVidw   = 12;
  localparam int unsigned PocketHalves = 2;
  localparam int unsigned FrameCntW    = 32;

  // PhHi: waiting for the first beat (upper half); PhLo: waiting for the second
  typedef enum logic [0:0] {
    PhHi = 1'b0,
    PhLo = 1'b1
  } phase_e;

endpackage

// File: rtl/jtframe_pocket_vidcap_asm.sv
// Beat assembler: gathers HALVES data beats into one pixel, first beat in the MS half.
// Flags a pixel cut short by a DE falling edge and discards it.
module jtframe_pocket_vidcap_asm
  import jtframe_pocket_pkg::*;
#(
  parameter int unsigned VIDW   = PocketVidw,
  parameter int unsigned HALVES = PocketHalves
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [VIDW-1:0]        vid_i,
  input  logic                   beat_i,
  input  logic                   de_fall_i,
  input  logic                   clr_i,
  output logic                   cpl_o,
  output logic [VIDW*HALVES-1:0] pxl_o,
  output logic                   half_err_o
);

  if (HALVES == 1) begin : g_single
    logic unused_ok;
    assign unused_ok  = ^{clk_i, rst_i, de_fall_i, clr_i};
    assign cpl_o      = beat_i;
    assign pxl_o      = vid_i;
    assign half_err_o = 1'b0;
  end else begin : g_pair
    phase_e            phase_q, phase_d;
    logic [VIDW-1:0]   hi_q, hi_d;
    logic              cpl, herr;

    always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      cpl     = 1'b0;
      herr    = 1'b0;
      if (beat_i) begin
        if (phase_q == PhHi) begin
          hi_d    = vid_i;
          phase_d = PhLo;
        end else begin
          cpl     = 1'b1;
          phase_d = PhHi;
        end
      end else if (de_fall_i && phase_q == PhLo) begin
        herr    = 1'b1;
        phase_d = PhHi;
      end
      // A frame close realigns the phase even if a beat landed this cycle
      if (clr_i) phase_d = PhHi;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        phase_q <= PhHi;
        hi_q    <= '0;
      end else begin
        phase_q <= phase_d;
        hi_q    <= hi_d;
      end
    end

    assign cpl_o      = cpl;
    assign pxl_o      = {hi_q, vid_i};
    assign half_err_o = herr;
  end

endmodule

// File: rtl/jtframe_pocket_vidcap.sv
// Scaler video capture: tags assembled pixels with X/Y and keeps per-frame statistics
// (frame count, non-empty lines, line-length consistency, partial pixels, saturation).
module jtframe_pocket_vidcap
  import jtframe_pocket_pkg::*;
#(
  parameter int unsigned VIDW   = PocketVidw,
  parameter int unsigned HALVES = PocketHalves,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [VIDW-1:0]        vid_i,
  input  logic                   de_i,
  input  logic                   skip_i,
  input  logic                   vs_i,
  input  logic                   hs_i,
  output logic [VIDW*HALVES-1:0] pxl_o,
  output logic                   pxl_valid_o,
  output logic [XW-1:0]          pxl_x_o,
  output logic [YW-1:0]          pxl_y_o,
  output logic [FrameCntW-1:0]   frame_cnt_o,
  output logic                   frame_done_o,
  output logic [YW-1:0]          frame_lines_o,
  output logic                   line_err_o,
  output logic                   half_err_o,
  output logic                   ovf_o
);

  localparam int unsigned PXLW = VIDW * HALVES;
  localparam logic [XW-1:0] XMax = '1;
  localparam logic [YW-1:0] YMax = '1;

  logic hs_q, vs_q, de_q;
  logic hs_rise, vs_rise, de_fall, beat;
  logic asm_cpl, asm_half_err, frame_close;
  logic [PXLW-1:0] asm_pxl;

  logic [XW-1:0]        x_q, x_d, ref_len_q, ref_len_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 ref_set_q, ref_set_d;
  logic                 line_has_q, line_has_d, frame_has_q, frame_has_d;
  logic [PXLW-1:0]      pxl_q, pxl_d;
  logic                 pxl_valid_q, pxl_valid_d;
  logic [XW-1:0]        pxl_x_q, pxl_x_d;
  logic [YW-1:0]        pxl_y_q, pxl_y_d;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic [YW-1:0]        frame_lines_q, frame_lines_d;
  logic                 line_err_q, line_err_d;
  logic                 half_err_q, half_err_d;
  logic                 ovf_q, ovf_d;

  assign hs_rise = hs_i & ~hs_q;
  assign vs_rise = vs_i & ~vs_q;
  assign de_fall = de_q & ~de_i;
  assign beat    = de_i & ~skip_i;
  // Same condition as the frame-close branch below, kept outside to feed the assembler
  assign frame_close = vs_rise & (frame_has_q | asm_cpl);

  jtframe_pocket_vidcap_asm #(
    .VIDW   (VIDW),
    .HALVES (HALVES)
  ) u_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .vid_i      (vid_i),
    .beat_i     (beat),
    .de_fall_i  (de_fall),
    .clr_i      (frame_close),
    .cpl_o      (asm_cpl),
    .pxl_o      (asm_pxl),
    .half_err_o (asm_half_err)
  );

  // Pixel, then line close, then frame close: a shared HS/VS cycle closes the line first
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    ref_len_d     = ref_len_q;
    ref_set_d     = ref_set_q;
    line_has_d    = line_has_q;
    frame_has_d   = frame_has_q;
    pxl_d         = pxl_q;
    pxl_valid_d   = 1'b0;
    pxl_x_d       = pxl_x_q;
    pxl_y_d       = pxl_y_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    frame_lines_d = frame_lines_q;
    // Flags survive the frame_done cycle and drop on the next one
    line_err_d    = line_err_q & ~frame_done_q;
    half_err_d    = half_err_q & ~frame_done_q;
    ovf_d         = ovf_q & ~frame_done_q;

    if (asm_half_err) half_err_d = 1'b1;

    if (asm_cpl) begin
      pxl_valid_d = 1'b1;
      pxl_d       = asm_pxl;
      pxl_x_d     = x_q;
      pxl_y_d     = y_q;
      if (x_q == XMax) ovf_d = 1'b1;
      else             x_d   = x_q + 1'b1;
      line_has_d  = 1'b1;
      frame_has_d = 1'b1;
    end

    if (hs_rise && line_has_d) begin
      if (!ref_set_d) begin
        ref_len_d = x_d;
        ref_set_d = 1'b1;
      end else if (x_d != ref_len_d) begin
        line_err_d = 1'b1;
      end
      if (y_d == YMax) ovf_d = 1'b1;
      else             y_d   = y_d + 1'b1;
      x_d        = '0;
      line_has_d = 1'b0;
    end

    if (frame_close) begin
      frame_done_d  = 1'b1;
      frame_lines_d = (line_has_d && y_d != YMax) ? y_d + 1'b1 : y_d;
      frame_cnt_d   = frame_cnt_q + 1'b1;
      x_d           = '0;
      y_d           = '0;
      ref_set_d     = 1'b0;
      line_has_d    = 1'b0;
      frame_has_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      ref_len_q     <= '0;
      ref_set_q     <= 1'b0;
      line_has_q    <= 1'b0;
      frame_has_q   <= 1'b0;
      pxl_q         <= '0;
      pxl_valid_q   <= 1'b0;
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_lines_q <= '0;
      line_err_q    <= 1'b0;
      half_err_q    <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      hs_q          <= hs_i;
      vs_q          <= vs_i;
      de_q          <= de_i;
      x_q           <= x_d;
      y_q           <= y_d;
      ref_len_q     <= ref_len_d;
      ref_set_q     <= ref_set_d;
      line_has_q    <= line_has_d;
      frame_has_q   <= frame_has_d;
      pxl_q         <= pxl_d;
      pxl_valid_q   <= pxl_valid_d;
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
      frame_lines_q <= frame_lines_d;
      line_err_q    <= line_err_d;
      half_err_q    <= half_err_d;
      ovf_q         <= ovf_d;
    end
  end

  assign pxl_o         = pxl_q;
  assign pxl_valid_o   = pxl_valid_q;
  assign pxl_x_o       = pxl_x_q;
  assign pxl_y_o       = pxl_y_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_done_o  = frame_done_q;
  assign frame_lines_o = frame_lines_q;
  assign line_err_o    = line_err_q;
  assign half_err_o    = half_err_q;
  assign ovf_o         = ovf_q;

endmodule

// File: doc/jtframe_pocket_vidcap.md
# jtframe_pocket_vidcap

Simulation-side capture block for the Pocket target harness. Samples the scaler video bus (data, DE, skip, HS, VS) and reassembles pixels from one or more data beats. Emits pixels tagged with X/Y coordinates, plus per-frame statistics (frame count, lines, line-length consistency) for frame dumping and self-checking. It sits alongside the SDRAM model in the game-level bench and generalises the fixed 12-bit scaler hookup to any beat width and beat count.

## Interface

Parameters:
- VIDW, 12, width of one scaler data beat
- HALVES, 2, beats per pixel (1 or 2); pixel width PXLW = VIDW*HALVES
- XW, 10, pixel X counter width
- YW, 9, line Y counter width

Ports:
- clk  in  1  scaler clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- vid  in  VIDW  data beat
- de  in  1  data enable
- skip  in  1  beat not valid, ignore
- vs  in  1  vertical sync, active-high
- hs  in  1  horizontal sync, active-high
- pxl  out  PXLW  assembled pixel, first beat in MS half
- pxl_valid  out  1  one-cycle strobe, pxl/pxl_x/pxl_y valid
- pxl_x  out  XW  column of pxl
- pxl_y  out  YW  row of pxl
- frame_cnt  out  32  completed frames
- frame_done  out  1  one-cycle strobe at frame close
- frame_lines  out  YW  non-empty lines in the closed frame
- line_err  out  1  sticky per frame: line length differs from the first line
- half_err  out  1  sticky per frame: DE fell with a partial pixel
- ovf  out  1  sticky per frame: X or Y saturated

## Operation

- All outputs reset to 0. Internal state at reset: phase=0, x=0, y=0, ref_len=0, ref_set=0, line_has_pxl=0, frame_has_pxl=0.
- A beat is accepted when de=1 and skip=0. A skip cycle holds phase and data.
- HALVES=2: phase 0 stores vid into the upper half; phase 1 completes the pixel. HALVES=1: every beat completes a pixel.
- Pixel complete:
  - next cycle: pxl_valid=1, pxl, pxl_x=x, pxl_y=y
  - x increments, saturating at 2^XW-1; saturation sets ovf
  - line_has_pxl=1, frame_has_pxl=1
- de falling edge with phase=1: the partial pixel is discarded, phase=0, half_err=1.
- hs rising edge (line close), only if line_has_pxl:
  - if !ref_set: ref_len=x, ref_set=1
  - else if x!=ref_len: line_err=1
  - y increments (saturating, sets ovf), x=0, line_has_pxl=0
  - empty lines leave y unchanged
- vs rising edge (frame close), only if frame_has_pxl:
  - frame_done=1 for one cycle
  - frame_lines = y, plus 1 if the current line has pixels
  - frame_cnt increments, wrapping at 2^32
  - y=0, x=0, phase=0, ref_set=0
  - line_err, half_err and ovf clear
  - a VS with no pixels in the frame does nothing
- hs and vs rising in the same cycle: the line close is applied first, then the frame close. The open line is therefore counted and length-checked. The flags seen at frame_done are the pre-clear values.
- Edges are detected against registered copies of hs, vs and de. Those registers reset to 0, so a signal high at reset release counts as a rising edge on the first cycle.

## Timing

- Pixel latency: pxl_valid rises one clk after the completing beat.
- frame_done, frame_lines and frame_cnt update one clk after the cycle in which the vs rising edge is sampled.
- Flags go high one clk after the causing event. They stay high through the frame_done cycle and clear on the following cycle.
- Throughput: one pixel per HALVES accepted beats, with no stall.
- Reset mid-line or mid-frame discards all partial state. Captured frames are not replayed.

## Structure

- Shared package jtframe_pocket_pkg holds:
  - localparam for the default VIDW/HALVES pair of the Pocket scaler (12/2)
  - the 32-bit frame counter width constant
- Sub-module jtframe_pocket_vidcap_asm is the beat assembler: phase register, skip handling, half_err detect.
- Counters, edge detectors and the frame/line bookkeeping stay in the top module.

## Test plan

- HALVES=2, 4 lines x 3 pixels, beats 0x123,0x456 repeated, then VS → 12 pxl_valid strobes with pxl=0x123456 and x 0..2, y 0..3. Then frame_done with frame_lines=4, frame_cnt=1, all flags 0.
- skip=1 inserted between the two beats of a pixel → same pxl as without skip, no extra strobe.
- Line 2 with 4 pixels in a 3-pixel frame → line_err=1 from the cycle after that HS; seen at frame_done; 0 one cycle after.
- DE drops after 1 beat (HALVES=2) → half_err=1, no pxl_valid for the partial pixel, next pixel assembles correctly.
- HS and VS rise together on the last line → frame_lines includes that line; its length is checked.
- XW=2 with a 5-pixel line → pxl_x sticks at 3 and ovf=1. Reset asserted mid-frame → all outputs 0 and the next frame starts at x=0, y=0.
